inst_cache_dm: RTL and testbench

//  Direct-mapped, read-only instruction cache with a one-word line. Sits between the core's sram-like inst port
//  (physical address from mmu) and the inst port of cpu_axi_interface. Hits are served locally. Misses issue a
//  one-word sram-like read downstream and allocate the returned word. At most one request outstanding.

---
 rtl/cache_pkg.sv | 18 +
 rtl/inst_cache_array.sv | 54 +++++
 rtl/inst_cache_dm.sv | 181 ++++++++++++++++++
 tb/tb_inst_cache_dm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM encoding, tag-width derivation and size constant for the instruction cache
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_MISS   = 2'd2,
        ST_REFILL = 2'd3
    } cache_state_e;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Word-granular lines: 30 address bits remain after dropping addr[1:0].
    function automatic int tag_width(input int index_width);
        return 30 - index_width;
    endfunction

endpackage

// File: rtl/inst_cache_array.sv
// rtl/inst_cache_array.sv - valid/tag/data storage with async read and single-cycle write
module inst_cache_array
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = 10,
    parameter int TAG_WIDTH   = tag_width(INDEX_WIDTH)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output logic                   rd_valid,
    output logic [TAG_WIDTH-1:0]   rd_tag,
    output logic [31:0]            rd_data,
    input  logic                   we,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic [31:0]            wr_data
);

    localparam int LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     valid_d;
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [31:0]          data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/data contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/inst_cache_dm.sv
// rtl/inst_cache_dm.sv - direct-mapped one-word-line instruction cache; ICACHE_PERF_CNT_EN adds hit/miss counters
module inst_cache_dm
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_inst_req,
    input  logic        cpu_inst_wr,
    input  logic [1:0]  cpu_inst_size,
    input  logic [31:0] cpu_inst_addr,
    input  logic [31:0] cpu_inst_wdata,
    output logic [31:0] cpu_inst_rdata,
    output logic        cpu_inst_addr_ok,
    output logic        cpu_inst_data_ok,
    output logic        cache_inst_req,
    output logic        cache_inst_wr,
    output logic [1:0]  cache_inst_size,
    output logic [31:0] cache_inst_addr,
    output logic [31:0] cache_inst_wdata,
    input  logic [31:0] cache_inst_rdata,
    input  logic        cache_inst_addr_ok,
    input  logic        cache_inst_data_ok
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);

    localparam int TAG_WIDTH = tag_width(INDEX_WIDTH);

    cache_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic         wr_q, wr_d;
    logic [1:0]   size_q, size_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [31:0]  rdata_q, rdata_d;

    logic [INDEX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   rd_valid;
    logic [TAG_WIDTH-1:0]   rd_tag;
    logic [31:0]            rd_data;
    logic                   hit;
    logic                   fill_we;

    assign idx = addr_q[INDEX_WIDTH+1:2];
    assign tag = addr_q[31:32-TAG_WIDTH];
    assign hit = rd_valid && (rd_tag == tag) && !wr_q;

    inst_cache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_array (
        .clk      (clk),
        .resetn   (resetn),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (fill_we),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_data  (cache_inst_rdata)
    );

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wr_d             = wr_q;
        size_d           = size_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        cpu_inst_addr_ok = 1'b0;
        cpu_inst_data_ok = 1'b0;
        cache_inst_req   = 1'b0;
        fill_we          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cpu_inst_addr_ok = cpu_inst_req;
                if (cpu_inst_req) begin
                    addr_d  = cpu_inst_addr;
                    wr_d    = cpu_inst_wr;
                    size_d  = cpu_inst_size;
                    wdata_d = cpu_inst_wdata;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit) begin
                    cpu_inst_data_ok = 1'b1;
                    rdata_d          = rd_data;
                    state_d          = ST_IDLE;
                end else begin
                    state_d = ST_MISS;
                end
            end
            ST_MISS: begin
                cache_inst_req = 1'b1;
                if (cache_inst_addr_ok) begin
                    // Same-cycle accept and response completes without visiting REFILL.
                    if (cache_inst_data_ok) begin
                        cpu_inst_data_ok = 1'b1;
                        rdata_d          = cache_inst_rdata;
                        fill_we          = !wr_q;
                        state_d          = ST_IDLE;
                    end else begin
                        state_d = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                if (cache_inst_data_ok) begin
                    cpu_inst_data_ok = 1'b1;
                    rdata_d          = cache_inst_rdata;
                    fill_we          = !wr_q;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // rdata_d equals the live response when data_ok is high and the held value otherwise.
    assign cpu_inst_rdata   = rdata_d;
    assign cache_inst_wr    = wr_q;
    assign cache_inst_size  = size_q;
    assign cache_inst_addr  = addr_q;
    assign cache_inst_wdata = wdata_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == ST_LOOKUP) begin
            if (hit) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end else if (!wr_q) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache_dm.sv
// tb/tb_inst_cache_dm.sv - directed and randomized self-checking bench for inst_cache_dm
module tb_inst_cache_dm;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_inst_req;
    logic        cpu_inst_wr;
    logic [1:0]  cpu_inst_size;
    logic [31:0] cpu_inst_addr;
    logic [31:0] cpu_inst_wdata;
    logic [31:0] cpu_inst_rdata;
    logic        cpu_inst_addr_ok;
    logic        cpu_inst_data_ok;
    logic        cache_inst_req;
    logic        cache_inst_wr;
    logic [1:0]  cache_inst_size;
    logic [31:0] cache_inst_addr;
    logic [31:0] cache_inst_wdata;
    logic [31:0] cache_inst_rdata;
    logic        cache_inst_addr_ok;
    logic        cache_inst_data_ok;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hit_cnt;
    logic [31:0] perf_miss_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    // Resident line per index, stored as the word address it holds.
    logic [29:0] line_waddr [int];
    logic [31:0] line_data  [int];

    inst_cache_dm #(.INDEX_WIDTH(10)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .cpu_inst_req       (cpu_inst_req),
        .cpu_inst_wr        (cpu_inst_wr),
        .cpu_inst_size      (cpu_inst_size),
        .cpu_inst_addr      (cpu_inst_addr),
        .cpu_inst_wdata     (cpu_inst_wdata),
        .cpu_inst_rdata     (cpu_inst_rdata),
        .cpu_inst_addr_ok   (cpu_inst_addr_ok),
        .cpu_inst_data_ok   (cpu_inst_data_ok),
        .cache_inst_req     (cache_inst_req),
        .cache_inst_wr      (cache_inst_wr),
        .cache_inst_size    (cache_inst_size),
        .cache_inst_addr    (cache_inst_addr),
        .cache_inst_wdata   (cache_inst_wdata),
        .cache_inst_rdata   (cache_inst_rdata),
        .cache_inst_addr_ok (cache_inst_addr_ok),
        .cache_inst_data_ok (cache_inst_data_ok)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .perf_hit_cnt       (perf_hit_cnt),
        .perf_miss_cnt      (perf_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_addr_ok"}, {31'd0, cpu_inst_addr_ok}, 32'd0);
        chk({tag, "_data_ok"}, {31'd0, cpu_inst_data_ok}, 32'd0);
        chk({tag, "_rdata"}, cpu_inst_rdata, 32'd0);
        chk({tag, "_creq"}, {31'd0, cache_inst_req}, 32'd0);
        chk({tag, "_caddr"}, cache_inst_addr, 32'd0);
        chk({tag, "_cwr"}, {31'd0, cache_inst_wr}, 32'd0);
        chk({tag, "_csize"}, {30'd0, cache_inst_size}, 32'd0);
        chk({tag, "_cwdata"}, cache_inst_wdata, 32'd0);
    endtask

    // Drives one full transaction; called just after a falling edge with the DUT idle.
    task automatic xact(input logic [31:0] a, input logic wr, input logic [1:0] sz,
                        input logic [31:0] wd, input int stall_a, input int stall_d,
                        input bit combined, input logic [31:0] dn);
        int  idx;
        bit  exp_hit;
        idx = int'(a[11:2]);
        exp_hit = !wr && line_waddr.exists(idx) && (line_waddr[idx] == a[31:2]);
        cpu_inst_req   = 1'b1;
        cpu_inst_wr    = wr;
        cpu_inst_size  = sz;
        cpu_inst_addr  = a;
        cpu_inst_wdata = wd;
        #1 chk("addr_ok", {31'd0, cpu_inst_addr_ok}, 32'd1);
        @(negedge clk);
        cpu_inst_req  = 1'b0;
        cpu_inst_addr = $urandom;
        #1;
        if (exp_hit) begin
            exp_hits++;
            chk("hit_data_ok", {31'd0, cpu_inst_data_ok}, 32'd1);
            chk("hit_rdata", cpu_inst_rdata, line_data[idx]);
            chk("hit_no_creq", {31'd0, cache_inst_req}, 32'd0);
            @(negedge clk);
            #1 chk("hit_hold", cpu_inst_rdata, line_data[idx]);
            chk("hit_pulse", {31'd0, cpu_inst_data_ok}, 32'd0);
            return;
        end
        if (!wr) exp_misses++;
        chk("miss_no_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < stall_a; i++) begin
            #1 chk("stall_creq", {31'd0, cache_inst_req}, 32'd1);
            chk("stall_caddr", cache_inst_addr, a);
            chk("stall_cwr", {31'd0, cache_inst_wr}, {31'd0, wr});
            chk("stall_csize", {30'd0, cache_inst_size}, {30'd0, sz});
            chk("stall_cwdata", cache_inst_wdata, wd);
            chk("stall_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
            @(negedge clk);
        end
        cache_inst_addr_ok = 1'b1;
        if (combined) begin
            cache_inst_data_ok = 1'b1;
            cache_inst_rdata   = dn;
        end
        #1 chk("acc_creq", {31'd0, cache_inst_req}, 32'd1);
        chk("acc_caddr", cache_inst_addr, a);
        chk("acc_data_ok", {31'd0, cpu_inst_data_ok}, {31'd0, combined});
        if (combined) chk("comb_rdata", cpu_inst_rdata, dn);
        @(negedge clk);
        cache_inst_addr_ok = 1'b0;
        cache_inst_data_ok = 1'b0;
        cache_inst_rdata   = $urandom;
        if (!combined) begin
            for (int i = 0; i < stall_d; i++) begin
                #1 chk("refill_creq", {31'd0, cache_inst_req}, 32'd0);
                chk("refill_wait", {31'd0, cpu_inst_data_ok}, 32'd0);
                @(negedge clk);
            end
            cache_inst_data_ok = 1'b1;
            cache_inst_rdata   = dn;
            #1 chk("refill_data_ok", {31'd0, cpu_inst_data_ok}, 32'd1);
            chk("refill_rdata", cpu_inst_rdata, dn);
            @(negedge clk);
            cache_inst_data_ok = 1'b0;
            cache_inst_rdata   = $urandom;
        end
        #1 chk("done_pulse", {31'd0, cpu_inst_data_ok}, 32'd0);
        chk("done_hold", cpu_inst_rdata, dn);
        chk("done_creq", {31'd0, cache_inst_req}, 32'd0);
        if (!wr) begin
            line_waddr[idx] = a[31:2];
            line_data[idx]  = dn;
        end
    endtask

    initial begin
        logic [19:0] tags [3];
        logic [31:0] a;
        logic        wr;
        tags[0] = 20'hBFC00;
        tags[1] = 20'h12345;
        tags[2] = 20'hBFC01;

        resetn             = 1'b0;
        cpu_inst_req       = 1'b0;
        cpu_inst_wr        = 1'b0;
        cpu_inst_size      = SIZE_WORD;
        cpu_inst_addr      = '0;
        cpu_inst_wdata     = '0;
        cache_inst_rdata   = '0;
        cache_inst_addr_ok = 1'b0;
        cache_inst_data_ok = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_idle_zero("reset");
        resetn = 1'b1;
        @(negedge clk);

        xact(32'hBFC0_0000, 1'b0, SIZE_WORD, 32'h0, 3, 1, 1'b0, 32'h2408_0001);
        xact(32'hBFC0_0000, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b0, 32'h0);
        xact(32'hBFC0_1000, 1'b0, SIZE_WORD, 32'h0, 1, 2, 1'b0, 32'h0000_0000);
        xact(32'hBFC0_0000, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b0, 32'h2408_0001);
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit_t3", perf_hit_cnt, 32'd1);
        chk("perf_miss_t3", perf_miss_cnt, 32'd3);
`endif
        xact(32'h1FAF_0000, 1'b1, 2'b01, 32'hDEAD_BEEF, 1, 1, 1'b0, 32'h5555_AAAA);
        xact(32'hBFC0_0000, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b0, 32'h0);
        xact(32'h1FAF_0000, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b0, 32'h1357_9BDF);

        // Reset while waiting in REFILL.
        cpu_inst_req  = 1'b1;
        cpu_inst_wr   = 1'b0;
        cpu_inst_addr = 32'h8000_0040;
        @(negedge clk);
        cpu_inst_req = 1'b0;
        @(negedge clk);
        cache_inst_addr_ok = 1'b1;
        @(negedge clk);
        cache_inst_addr_ok = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        exp_misses = 0;
        exp_hits   = 0;
        @(negedge clk);
        #1 chk_idle_zero("midreset");
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit_rst", perf_hit_cnt, 32'd0);
        chk("perf_miss_rst", perf_miss_cnt, 32'd0);
`endif
        resetn = 1'b1;
        line_waddr.delete();
        line_data.delete();
        @(negedge clk);
        cache_inst_data_ok = 1'b1;
        #1 chk("stray_data_ok", {31'd0, cpu_inst_data_ok}, 32'd0);
        @(negedge clk);
        cache_inst_data_ok = 1'b0;
        #1 chk("stray_state", {31'd0, cache_inst_req}, 32'd0);
        xact(32'h8000_0040, 1'b0, SIZE_WORD, 32'h0, 0, 1, 1'b0, 32'hCAFE_0040);
        xact(32'hBFC0_0000, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b1, 32'h2408_0001);
        xact(32'hBFC0_0000, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b0, 32'h0);
        xact(32'hBFC0_0003, 1'b1, SIZE_WORD, 32'h0BAD_0BAD, 2, 0, 1'b1, 32'h7777_0000);
        xact(32'hBFC0_0002, 1'b0, SIZE_WORD, 32'h0, 0, 0, 1'b0, 32'h0);

        for (int n = 0; n < 60; n++) begin
            a  = {tags[$urandom_range(0, 2)], 10'($urandom_range(0, 3)), 2'($urandom)};
            wr = ($urandom_range(0, 5) == 0);
            xact(a, wr, wr ? 2'($urandom_range(0, 2)) : SIZE_WORD, $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 3) == 0), $urandom);
        end
`ifdef ICACHE_PERF_CNT_EN
        chk("perf_hit_end", perf_hit_cnt, 32'(exp_hits));
        chk("perf_miss_end", perf_miss_cnt, 32'(exp_misses));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
